// File: rtl/i2c_slave.sv
// i2c_slave: single-address I2C target; oversamples SCL/SDA, ACKs SLAVE_ADDR,
// ports: clk/rst(sync, active-low), i2c_scl/i2c_sda bus, rx_*/tx_* local side, busy.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX,
    S_RX_ACK,
    S_TX,
    S_TX_ACK,
    S_WAIT
  } state_e;

  logic   scl_s1_q, scl_s2_q, scl_d_q;
  logic   sda_s1_q, sda_s2_q, sda_d_q;
  logic   scl_rise, scl_fall, sda_rise, sda_fall;
  logic   start_ev, stop_ev;
  logic   [7:0] byte_in;

  state_e state_q, state_d;
  logic   [2:0] cnt_q, cnt_d;
  logic   [7:0] sh_q, sh_d;
  logic   rw_q, rw_d;
  // second half of a two-fall ACK/turnaround window
  logic   ph_q, ph_d;
  logic   sda_low_q, sda_low_d;
  logic   [7:0] rx_data_q, rx_data_d;
  logic   rx_valid_q, rx_valid_d;
  logic   tx_req_q, tx_req_d;
  logic   busy_q, busy_d;

  assign scl_rise = scl_s2_q & ~scl_d_q;
  assign scl_fall = ~scl_s2_q & scl_d_q;
  assign sda_rise = sda_s2_q & ~sda_d_q;
  assign sda_fall = ~sda_s2_q & sda_d_q;
  assign start_ev = sda_fall & scl_s2_q;
  assign stop_ev  = sda_rise & scl_s2_q;
  assign byte_in  = {sh_q[6:0], sda_s2_q};

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_d_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_d_q  <= 1'b1;
    end else begin
      scl_s1_q <= i2c_scl;
      scl_s2_q <= scl_s1_q;
      scl_d_q  <= scl_s2_q;
      sda_s1_q <= i2c_sda;
      sda_s2_q <= sda_s1_q;
      sda_d_q  <= sda_s2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd7;
      sh_q       <= 8'h00;
      rw_q       <= 1'b0;
      ph_q       <= 1'b0;
      sda_low_q  <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      rw_q       <= rw_d;
      ph_q       <= ph_d;
      sda_low_q  <= sda_low_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    rw_d       = rw_q;
    ph_d       = ph_q;
    sda_low_d  = sda_low_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    if (start_ev) begin
      state_d   = S_ADDR;
      cnt_d     = 3'd7;
      ph_d      = 1'b0;
      busy_d    = 1'b0;
      sda_low_d = 1'b0;
    end else if (stop_ev) begin
      state_d   = S_IDLE;
      ph_d      = 1'b0;
      busy_d    = 1'b0;
      sda_low_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: sda_low_d = 1'b0;
        S_ADDR: begin
          if (scl_rise) begin
            sh_d = byte_in;
            if (cnt_q == 3'd0) begin
              cnt_d = 3'd7;
              ph_d  = 1'b0;
              if (byte_in[7:1] == SLAVE_ADDR) begin
                state_d = S_ADDR_ACK;
                rw_d    = byte_in[0];
              end else begin
                state_d = S_WAIT;
              end
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (!ph_q) begin
              ph_d      = 1'b1;
              sda_low_d = 1'b1;
              busy_d    = 1'b1;
              if (rw_q) begin
                tx_req_d = 1'b1;
                sh_d     = tx_data;
              end
            end else begin
              ph_d  = 1'b0;
              cnt_d = 3'd7;
              if (rw_q) begin
                state_d   = S_TX;
                sda_low_d = ~sh_q[7];
              end else begin
                state_d   = S_RX;
                sda_low_d = 1'b0;
              end
            end
          end
        end
        S_RX: begin
          if (scl_rise) begin
            sh_d = byte_in;
            if (cnt_q == 3'd0) begin
              rx_data_d  = byte_in;
              rx_valid_d = 1'b1;
              state_d    = S_RX_ACK;
              cnt_d      = 3'd7;
              ph_d       = 1'b0;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end
        S_RX_ACK: begin
          if (scl_fall) begin
            if (!ph_q) begin
              ph_d      = 1'b1;
              sda_low_d = 1'b1;
            end else begin
              ph_d      = 1'b0;
              sda_low_d = 1'b0;
              state_d   = S_RX;
            end
          end
        end
        S_TX: begin
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              sda_low_d = 1'b0;
              state_d   = S_TX_ACK;
              cnt_d     = 3'd7;
              ph_d      = 1'b0;
            end else begin
              sh_d      = {sh_q[6:0], 1'b0};
              sda_low_d = ~sh_q[6];
              cnt_d     = cnt_q - 3'd1;
            end
          end
        end
        S_TX_ACK: begin
          // ph_q set: master ACKed, next byte loaded, waiting for fall
          if (!ph_q) begin
            if (scl_rise) begin
              if (!sda_s2_q) begin
                ph_d     = 1'b1;
                tx_req_d = 1'b1;
                sh_d     = tx_data;
              end else begin
                state_d = S_WAIT;
                busy_d  = 1'b0;
              end
            end
          end else if (scl_fall) begin
            ph_d      = 1'b0;
            cnt_d     = 3'd7;
            sda_low_d = ~sh_q[7];
            state_d   = S_TX;
          end
        end
        S_WAIT: sda_low_d = 1'b0;
        default: begin
          state_d   = S_IDLE;
          sda_low_d = 1'b0;
        end
      endcase
    end
  end

  assign i2c_sda  = sda_low_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master driving i2c_slave,
// table vectors, hand sequences and random transactions vs a byte-level model.
module tb_i2c_slave;

  localparam int Q = 80;
  localparam logic [6:0] SADDR = 7'h50;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  wire  sda;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'hFF;
  logic rx_valid, tx_req, busy;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(SADDR)) dut (
    .clk      (clk),
    .rst      (rst),
    .i2c_scl  (scl),
    .i2c_sda  (sda),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;
  int rxv_cnt = 0;
  int txr_cnt = 0;
  int slave_low = 0;
  logic [7:0] rx_log[$];
  logic [7:0] txq[$];

  logic [7:0] wbuf[4];
  logic [7:0] ebuf[4];
  logic [7:0] rbuf[4];
  logic       dack[4];
  logic       aack;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt++;
      rx_log.push_back(rx_data);
    end
    if (tx_req) begin
      txr_cnt++;
      if (txq.size() > 0) void'(txq.pop_front());
    end
    if (rx_valid && tx_req) begin
      checks++;
      errors++;
      $display("FAIL pulse_overlap: got rx_valid=1 tx_req=1 expected not both");
    end
    if (sda === 1'b0 && !m_low) slave_low++;
    tx_data = (txq.size() > 0) ? txq[0] : 8'hFF;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic bit_io(input logic b, output logic seen);
    m_low = ~b;
    #Q;
    scl = 1'b1;
    #Q;
    seen = (sda === 1'b0) ? 1'b0 : 1'b1;
    #Q;
    scl = 1'b0;
    #Q;
  endtask

  task automatic bus_start();
    m_low = 1'b0;
    scl = 1'b1;
    #Q;
    m_low = 1'b1;
    #Q;
    scl = 1'b0;
    #Q;
  endtask

  task automatic bus_rstart();
    m_low = 1'b0;
    #Q;
    scl = 1'b1;
    #Q;
    m_low = 1'b1;
    #Q;
    scl = 1'b0;
    #Q;
  endtask

  task automatic bus_stop();
    m_low = 1'b1;
    #Q;
    scl = 1'b1;
    #Q;
    m_low = 1'b0;
    #(2 * Q);
  endtask

  task automatic byte_w(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(b[i], s);
    bit_io(1'b1, s);
    ack = ~s;
  endtask

  task automatic byte_r(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      b[i] = s;
    end
    bit_io(~mack, s);
  endtask

  // One full transaction plus all checks against supplied expectations.
  task automatic run_chk(input string tag, input logic [6:0] a,
                         input logic rw, input int n,
                         input logic eack, input int epul);
    int rv0, tr0;
    logic mb, eb;
    rx_log.delete();
    txq.delete();
    if (rw) for (int i = 0; i < n; i++) txq.push_back(wbuf[i]);
    @(negedge clk);
    @(negedge clk);
    slave_low = 0;
    rv0 = rxv_cnt;
    tr0 = txr_cnt;
    bus_start();
    byte_w({a, rw}, aack);
    mb = busy;
    for (int i = 0; i < n; i++) begin
      if (rw) byte_r(i != n - 1, rbuf[i]);
      else byte_w(wbuf[i], dack[i]);
    end
    eb = busy;
    chk({tag, " addr_ack"}, aack, eack);
    chk({tag, " busy_mid"}, mb, eack);
    chk({tag, " busy_end"}, eb, eack && !rw);
    if (rw) begin
      m_low = 1'b0;
      #(Q / 2);
      chk({tag, " sda_released"}, sda, 1'b1);
      for (int i = 0; i < n; i++)
        chk($sformatf("%s rd_byte%0d", tag, i), rbuf[i], ebuf[i]);
      chk({tag, " tx_req_cnt"}, txr_cnt - tr0, epul);
    end else begin
      for (int i = 0; i < n; i++)
        chk($sformatf("%s data_ack%0d", tag, i), dack[i], eack);
      chk({tag, " rx_valid_cnt"}, rxv_cnt - rv0, epul);
      chk({tag, " rx_log_size"}, rx_log.size(), epul);
      for (int i = 0; i < rx_log.size() && i < n; i++)
        chk($sformatf("%s rx_data%0d", tag, i), rx_log[i], ebuf[i]);
    end
    if (!eack) chk({tag, " slave_never_low"}, slave_low, 0);
    bus_stop();
    chk({tag, " busy_after_stop"}, busy, 1'b0);
  endtask

  typedef struct {
    logic [6:0] a;
    logic       rw;
    int         n;
    logic [7:0] d0, d1;
    logic       eack;
    int         epul;
    logic [7:0] e0, e1;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic s;
    logic [6:0] ra;
    logic rrw, mt;
    int rn, rv0, tr0;
    logic [7:0] b;

    tbl[0] = '{7'h50, 1'b0, 1, 8'hA5, 8'h00, 1'b1, 1, 8'hA5, 8'h00};
    tbl[1] = '{7'h51, 1'b0, 1, 8'h3C, 8'h00, 1'b0, 0, 8'h00, 8'h00};
    tbl[2] = '{7'h50, 1'b1, 1, 8'h3C, 8'h00, 1'b1, 1, 8'h3C, 8'h00};
    tbl[3] = '{7'h50, 1'b1, 2, 8'h81, 8'h7E, 1'b1, 2, 8'h81, 8'h7E};
    tbl[4] = '{7'h28, 1'b1, 1, 8'h55, 8'h00, 1'b0, 0, 8'hFF, 8'h00};
    tbl[5] = '{7'h50, 1'b0, 2, 8'h11, 8'hEE, 1'b1, 2, 8'h11, 8'hEE};

    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset rx_data", rx_data, 8'h00);
    chk("reset rx_valid", rx_valid, 1'b0);
    chk("reset tx_req", tx_req, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset sda", sda, 1'b1);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      wbuf[0] = tbl[k].d0;
      wbuf[1] = tbl[k].d1;
      ebuf[0] = tbl[k].e0;
      ebuf[1] = tbl[k].e1;
      run_chk($sformatf("vec%0d", k), tbl[k].a, tbl[k].rw, tbl[k].n,
              tbl[k].eack, tbl[k].epul);
    end

    // Repeated START: write 0x12, then Sr and a one-byte read.
    rx_log.delete();
    txq.delete();
    txq.push_back(8'h5A);
    @(negedge clk);
    @(negedge clk);
    rv0 = rxv_cnt;
    tr0 = txr_cnt;
    bus_start();
    byte_w(8'hA0, aack);
    byte_w(8'h12, dack[0]);
    chk("rs rx_data", rx_data, 8'h12);
    chk("rs wr_ack", dack[0], 1'b1);
    bus_rstart();
    byte_w(8'hA1, aack);
    chk("rs rd_addr_ack", aack, 1'b1);
    byte_r(1'b0, b);
    chk("rs rd_byte", b, 8'h5A);
    chk("rs rx_cnt", rxv_cnt - rv0, 1);
    chk("rs tx_cnt", txr_cnt - tr0, 1);
    bus_stop();

    // Reset in the middle of a write data byte.
    rx_log.delete();
    rv0 = rxv_cnt;
    bus_start();
    byte_w(8'hA0, aack);
    chk("rmid addr_ack", aack, 1'b1);
    b = 8'h96;
    for (int i = 7; i >= 4; i--) bit_io(b[i], s);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rmid busy", busy, 1'b0);
    chk("rmid rx_data", rx_data, 8'h00);
    chk("rmid rx_valid", rx_valid, 1'b0);
    chk("rmid tx_req", tx_req, 1'b0);
    rst = 1'b1;
    for (int i = 3; i >= 0; i--) bit_io(b[i], s);
    bit_io(1'b1, s);
    chk("rmid no_ack", s, 1'b1);
    chk("rmid rx_cnt", rxv_cnt - rv0, 0);
    bus_stop();

    // Reset while the target is pulling the address ACK low.
    bus_start();
    b = 8'hA0;
    for (int i = 7; i >= 0; i--) bit_io(b[i], s);
    m_low = 1'b0;
    repeat (2) @(negedge clk);
    chk("rack sda_driven", sda, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rack sda_released", sda, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    bit_io(1'b1, s);
    chk("rack ack_gone", s, 1'b1);
    bus_stop();

    // Random transactions against the byte-level model.
    for (int k = 0; k < 14; k++) begin
      mt  = 1'($urandom_range(0, 1));
      ra  = 7'($urandom_range(0, 127));
      if (mt) ra = SADDR;
      else if (ra == SADDR) ra = SADDR + 7'd1;
      rrw = 1'($urandom_range(0, 1));
      rn  = int'($urandom_range(1, 3));
      for (int i = 0; i < rn; i++) begin
        wbuf[i] = 8'($urandom_range(0, 255));
        ebuf[i] = (rrw && ra != SADDR) ? 8'hFF : wbuf[i];
      end
      run_chk($sformatf("rnd%0d", k), ra, rrw, rn, ra == SADDR,
              (ra == SADDR) ? rn : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
